// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - fetch state encoding and instruction field layout
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetchState_t;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 9;
  localparam int RA_HI  = 8;
  localparam int RA_LO  = 6;
  localparam int RB_HI  = 5;
  localparam int RB_LO  = 3;
  localparam int RC_HI  = 2;
  localparam int RC_LO  = 0;

  function automatic logic [6:0] opcodeOf(input logic [15:0] word);
    return word[OPC_HI:OPC_LO];
  endfunction

  function automatic logic [2:0] raOf(input logic [15:0] word);
    return word[RA_HI:RA_LO];
  endfunction

  function automatic logic [2:0] rbOf(input logic [15:0] word);
    return word[RB_HI:RB_LO];
  endfunction

  function automatic logic [2:0] rcOf(input logic [15:0] word);
    return word[RC_HI:RC_LO];
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - small synchronous FIFO holding {word, address} pairs
module instr_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           pushData,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic             doPush;
  logic             doPop;

  assign doPush = push && (count != FULL);
  assign doPop  = pop && (count != '0);
  assign head   = mem[rdPtr];

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (doPop) rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch PC, memory read handshake and redirect handling
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              ir_valid,
  output logic [DATA_W-1:0] ir_word,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              ir_load
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  fetchState_t       state;
  fetchState_t       stateNext;
  logic [ADDR_W-1:0] fetchPc;
  logic [ADDR_W-1:0] fetchPcNext;
  logic              memReqNext;
  logic [ADDR_W-1:0] memAddrNext;
  logic              push;
  logic              pop;
  logic              flush;
  logic [PTR_W:0]    fifoCount;
  logic [DATA_W+ADDR_W-1:0] fifoHead;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      fetchPc  <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
    end else begin
      state    <= stateNext;
      fetchPc  <= fetchPcNext;
      mem_req  <= memReqNext;
      mem_addr <= memAddrNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (!jump && fifoCount != FULL) stateNext = WAIT;
      WAIT:    if (mem_ack) stateNext = IDLE;
               else if (jump) stateNext = DISCARD;
      DISCARD: if (mem_ack) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // A jump always flushes; in DISCARD the FIFO is already empty so only the PC moves.
  always_comb begin
    flush       = jump;
    push        = (state == WAIT) && mem_ack && !jump;
    pop         = ir_load && ir_valid && !jump;
    fetchPcNext = fetchPc;
    if (jump) fetchPcNext = jump_addr;
    else if (push) fetchPcNext = fetchPc + 1'b1;
    memReqNext  = (stateNext != IDLE);
    memAddrNext = (state == IDLE && stateNext == WAIT) ? fetchPc : mem_addr;
  end

  instr_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(DATA_W + ADDR_W)
  ) fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .pushData({mem_data, mem_addr}),
    .pop     (pop),
    .flush   (flush),
    .count   (fifoCount),
    .head    (fifoHead)
  );

  assign ir_valid         = (fifoCount != '0);
  assign {ir_word, ir_pc} = fifoHead;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed vector bench for instr_fetch
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        memReq, memAck, jump, irValid, irLoad;
  logic [15:0] memAddr, memData, jumpAddr, irWord, irPc;
  logic        memReqW, memAckW, irValidW;
  logic [15:0] memAddrW, memDataW, irWordW, irPcW;
  int          ackDelay;
  int          waitCnt;
  int          nApplied;
  int          nMiss;

  instr_fetch #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000), .DEPTH(2)) dut (
    .clock(clock), .reset(reset),
    .mem_req(memReq), .mem_addr(memAddr), .mem_ack(memAck), .mem_data(memData),
    .jump(jump), .jump_addr(jumpAddr),
    .ir_valid(irValid), .ir_word(irWord), .ir_pc(irPc), .ir_load(irLoad)
  );

  instr_fetch #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'hFFFF), .DEPTH(2)) dutW (
    .clock(clock), .reset(reset),
    .mem_req(memReqW), .mem_addr(memAddrW), .mem_ack(memAckW), .mem_data(memDataW),
    .jump(1'b0), .jump_addr(16'h0000),
    .ir_valid(irValidW), .ir_word(irWordW), .ir_pc(irPcW), .ir_load(1'b1)
  );

  // Memory returns address ^ A5A5 after ackDelay wait cycles.
  assign memAck   = memReq && (waitCnt >= ackDelay);
  assign memData  = memAddr ^ 16'hA5A5;
  assign memAckW  = memReqW;
  assign memDataW = memAddrW ^ 16'hA5A5;

  always @(posedge clock or posedge reset) begin
    if (reset) waitCnt <= 0;
    else if (memReq && !memAck) waitCnt <= waitCnt + 1;
    else waitCnt <= 0;
  end

  typedef struct {
    logic        rst;
    logic        load;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] word;
    logic [15:0] pc;
    logic        chkW;
    logic        wReq;
    logic [15:0] wAddr;
    logic        wValid;
    logic [15:0] wWord;
    logic [15:0] wPc;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nApplied++;
    if (act !== exp) begin
      nMiss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    bit seen;
    nApplied = 0;
    nMiss    = 0;
    reset    = 1'b1;
    irLoad   = 1'b0;
    jump     = 1'b0;
    jumpAddr = 16'h0000;
    ackDelay = 0;

    //           rst   load  req   addr      valid word      pc        chkW  wReq  wAddr     wValid wWord     wPc
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 1'b0, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 16'h0000};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hA5A5, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 1'b1, 16'h5A5A, 16'hFFFF};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 16'hA5A5, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 16'hA5A5, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hA5A5, 16'h0000};
    for (int i = 5; i < 12; i++)
      vecs[i] = '{1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 16'hA5A5, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 16'h0001, 1'b1, 16'hA5A4, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 16'h0002, 1'b1, 16'hA5A4, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 16'hA5A4, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 16'h0002, 1'b1, 16'hA5A7, 16'h0002, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 16'h0003, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 16'h0003, 1'b1, 16'hA5A6, 16'h0003, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};

    for (int i = 0; i < 18; i++) begin
      reset  = vecs[i].rst;
      irLoad = vecs[i].load;
      step();
      check($sformatf("v%0d req", i), 32'(memReq), 32'(vecs[i].req));
      check($sformatf("v%0d addr", i), 32'(memAddr), 32'(vecs[i].addr));
      check($sformatf("v%0d valid", i), 32'(irValid), 32'(vecs[i].valid));
      if (vecs[i].valid || vecs[i].rst) begin
        check($sformatf("v%0d word", i), 32'(irWord), 32'(vecs[i].word));
        check($sformatf("v%0d pc", i), 32'(irPc), 32'(vecs[i].pc));
      end
      if (vecs[i].chkW) begin
        check($sformatf("v%0d w_req", i), 32'(memReqW), 32'(vecs[i].wReq));
        check($sformatf("v%0d w_addr", i), 32'(memAddrW), 32'(vecs[i].wAddr));
        check($sformatf("v%0d w_valid", i), 32'(irValidW), 32'(vecs[i].wValid));
        if (vecs[i].wValid || vecs[i].rst) begin
          check($sformatf("v%0d w_word", i), 32'(irWordW), 32'(vecs[i].wWord));
          check($sformatf("v%0d w_pc", i), 32'(irPcW), 32'(vecs[i].wPc));
        end
      end
    end

    // Jump while a slow read of addr 3 is in flight.
    irLoad   = 1'b0;
    ackDelay = 3;
    jump     = 1'b1;
    jumpAddr = 16'h0003;
    step();
    check("b_idle_jump valid", 32'(irValid), 32'd0);
    check("b_idle_jump req", 32'(memReq), 32'd0);
    jump = 1'b0;
    step();
    check("b_req3 req", 32'(memReq), 32'd1);
    check("b_req3 addr", 32'(memAddr), 32'h0003);
    jump     = 1'b1;
    jumpAddr = 16'h0040;
    step();
    jump = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("b_hold%0d req", k), 32'(memReq), 32'd1);
      check($sformatf("b_hold%0d addr", k), 32'(memAddr), 32'h0003);
      check($sformatf("b_hold%0d valid", k), 32'(irValid), 32'd0);
      step();
    end
    check("b_dropped req", 32'(memReq), 32'd0);
    check("b_dropped valid", 32'(irValid), 32'd0);
    step();
    check("b_new req", 32'(memReq), 32'd1);
    check("b_new addr", 32'(memAddr), 32'h0040);
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      step();
      if (irValid) seen = 1'b1;
    end
    check("b_first_valid seen", 32'(seen), 32'd1);
    check("b_first pc", 32'(irPc), 32'h0040);
    check("b_first word", 32'(irWord), 32'hA5E5);
    check("b_first opcode", 32'(opcodeOf(irWord)), 32'h52);

    // Jump and ir_load together with two words buffered.
    reset = 1'b1;
    step();
    reset    = 1'b0;
    ackDelay = 0;
    for (int k = 0; k < 5; k++) step();
    check("c_full valid", 32'(irValid), 32'd1);
    check("c_full req", 32'(memReq), 32'd0);
    jump     = 1'b1;
    irLoad   = 1'b1;
    jumpAddr = 16'h0100;
    step();
    jump   = 1'b0;
    irLoad = 1'b0;
    check("c_flush valid", 32'(irValid), 32'd0);
    check("c_flush req", 32'(memReq), 32'd0);
    step();
    check("c_req req", 32'(memReq), 32'd1);
    check("c_req addr", 32'(memAddr), 32'h0100);
    step();
    check("c_word valid", 32'(irValid), 32'd1);
    check("c_word pc", 32'(irPc), 32'h0100);
    check("c_word word", 32'(irWord), 32'hA4A5);
    ackDelay = 5;
    step();
    check("c_next req", 32'(memReq), 32'd1);
    check("c_next addr", 32'(memAddr), 32'h0101);

    // Asynchronous reset mid-request with data buffered.
    #2 reset = 1'b1;
    #1;
    check("d_rst req", 32'(memReq), 32'd0);
    check("d_rst addr", 32'(memAddr), 32'h0000);
    check("d_rst valid", 32'(irValid), 32'd0);
    check("d_rst word", 32'(irWord), 32'h0000);
    check("d_rst pc", 32'(irPc), 32'h0000);
    check("d_rst w_req", 32'(memReqW), 32'd0);
    check("d_rst w_addr", 32'(memAddrW), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
    $finish;
  end

endmodule
